sdcard_spi_master: RTL and testbench
====================================

Name: sdcard_spi_master

Overview:
- Hardware SPI mode-0 byte engine for the SD card. Replaces the bit-banged SDCard IO device.
- Sits on the SoC IO page as two one-hot word selects: control/status (sel_cntl) and data (sel_dat).
- A CPU write to the data register launches an 8-bit full-duplex transfer. A read of the data register returns the byte received.
- wbusy/rbusy stall the processor while a transfer is in flight, so firmware needs no polling loop.

Parameters:
- INIT_DIV, 63: reset value of the clock divider. SPI half-period = (div+1) clk cycles; 63 at 50 MHz gives ≈390 kHz for card init.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rstrb  in  1  IO read strobe, one cycle
- wstrb  in  1  IO write strobe, one cycle
- sel_cntl  in  1  one-hot select, control/status register
- sel_dat  in  1  one-hot select, data register
- wdata  in  32  write data
- rdata  out  32  read data; 0 when neither select is active (OR-combined on IO bus)
- wbusy  out  1  write stall
- rbusy  out  1  read stall
- CLK  out  1  SPI clock
- MOSI  out  1  SPI data to card
- MISO  in  1  SPI data from card
- CS_N  out  1  card chip select, active-low

Behaviour:
- Reset (async, reset_n=0, applies mid-transfer too):
  - state=IDLE, CS_N=1, CLK=0, MOSI=1, div=INIT_DIV, rx byte=0xFF, all counters=0, wbusy=rbusy=0.
  - Any transfer in progress is aborted with no partial result.
- States:
  - IDLE: CLK=0, MOSI held at last driven bit (1 after reset).
  - XFER: transfer active, drives 8 bits.
- Transfer start:
  - IDLE & wstrb & sel_dat → load tx shift register with wdata[7:0] and drive MOSI=wdata[7] on the next edge.
  - bitcnt=0, divcnt=0, go to XFER.
- Clocking:
  - In XFER, divcnt counts 0..div. When divcnt==div: divcnt←0 and CLK toggles.
  - Rising CLK edge: rx←{rx[6:0],MISO}.
  - Falling CLK edge with bitcnt<7: bitcnt++, MOSI←next tx bit, MSB first.
  - Falling CLK edge with bitcnt==7: go to IDLE, rx byte becomes readable.
- Latency:
  - Exactly 16·(div+1) cycles in XFER.
  - wbusy rises the cycle after the accepting write and falls in the cycle state returns to IDLE.
- Busy signals:
  - wbusy = (state==XFER). Any write while busy is ignored, so no transfer is queued and cntl is unchanged.
  - rbusy = (state==XFER) & sel_dat. cntl reads are never stalled.
- Read decode (combinational):
  - sel_dat: {24'b0, rx}.
  - sel_cntl: {9'b0, crc7[6:0] (0 if feature absent), div[7:0], 6'b0, CS_N, busy}.
  - Both selects active simultaneously: OR of both.
- Control write (IDLE only):
  - CS_N←wdata[1], div←wdata[15:8].
  - wdata[16]=1 clears CRC (feature).
  - CS_N changes in the cycle after the write.
- Simultaneous events:
  - sel_cntl & sel_dat in the same write: apply the cntl fields, then start the transfer using the new div.
  - div=0: CLK toggles every cycle, 16-cycle transfer.
  - div=255: 4096-cycle transfer.
- CS_N is only software-driven and does not change automatically around transfers.

Optional Feature:
- Macro: SDCARD_SPI_CRC7_EN.
- Defined:
  - 7-bit CRC register, polynomial x^7+x^3+1, updated with each transmitted bit on its falling CLK edge.
  - Reset value 0. Cleared by a cntl write with bit16=1; clear takes priority over a transfer started in the same cycle.
  - Readable at cntl[22:16].
- Undefined: no CRC logic, cntl[22:16] reads 0, bit16 ignored.

Decomposition:
- Package sdcard_spi_pkg:
  - state enum {IDLE,XFER}.
  - Register field positions: BUSY_BIT=0, CSN_BIT=1, DIV_LSB=8, CRC_CLR_BIT=16, CRC_LSB=16.
  - CRC7_POLY=7'h09.
- Sub-module sd_crc7: serial bit-in CRC with enable and sync clear. Instantiated only under SDCARD_SPI_CRC7_EN.

Test Plan:
1. Reset, then read cntl → 0x00003F02 (div=63, CS_N=1, busy=0). Outputs CLK=0, MOSI=1, CS_N=1.
2. div=0 via cntl write 0x00000000 (CS_N=0). MISO looped to MOSI. Write dat 0xA5 → wbusy high exactly 16 cycles. Read dat → 0x000000A5. CLK shows 8 rising edges, MOSI MSB first 1,0,1,0,0,1,0,1.
3. div=3, MISO tied 0. Write 0xFF → transfer lasts 64 cycles. Read dat → 0x00. A dat read issued mid-transfer holds rbusy until IDLE.
4. CRC (feature on): clear, send 0x40,00,00,00,00 → cntl[22:16]=0x4A. Clear, send 0x48,00,00,01,AA → 0x43.
5. Assert reset_n=0 at bit 4 of a div=7 transfer → same cycle CS_N=1, CLK=0, MOSI=1. After release, busy=0, dat reads 0xFF, div=63.
6. While busy, write cntl 0x00000500 and dat 0x12 → both ignored; div still the old value and no second transfer starts.

Source files
------------

// File: rtl/sdcard_spi_pkg.sv
// Shared types, register field positions and the CRC7 step for the SD card SPI master.
package sdcard_spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   localparam int BUSY_BIT    = 0;
   localparam int CSN_BIT     = 1;
   localparam int DIV_LSB     = 8;
   localparam int CRC_CLR_BIT = 16;
   localparam int CRC_LSB     = 16;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   // One serial step of x^7+x^3+1, MSB-first data.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial bit-in CRC7 accumulator with enable and synchronous clear (clear wins).
module sd_crc7
   import sdcard_spi_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 7'h00;
      end else if (en) begin
         crc_d = crc7_step(crc_q, din);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 7'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sdcard_spi_master.sv
// SPI mode-0 byte engine for the SD card on the IO page (cntl/status + data registers).
// Optional CRC7 of transmitted bits when SDCARD_SPI_CRC7_EN is defined.
//
// state | meaning
// IDLE  | CLK low, MOSI holds last bit, cntl/dat writes accepted
// XFER  | 8-bit full-duplex shift in progress, processor stalled via wbusy/rbusy
module sdcard_spi_master
   import sdcard_spi_pkg::*;
#(
   parameter logic [7:0] INIT_DIV = 8'd63
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rstrb,
   input  logic        wstrb,
   input  logic        sel_cntl,
   input  logic        sel_dat,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        wbusy,
   output logic        rbusy,
   output logic        CLK,
   output logic        MOSI,
   input  logic        MISO,
   output logic        CS_N
);

   state_e     state_q,  state_d;
   logic [7:0] div_q,    div_d;
   logic [7:0] divcnt_q, divcnt_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic       clk_q,    clk_d;
   logic       mosi_q,   mosi_d;
   logic       csn_q,    csn_d;
   logic [7:0] tx_q,     tx_d;
   logic [7:0] rx_sh_q,  rx_sh_d;
   logic [7:0] rx_q,     rx_d;

   logic        busy;
   logic        wr_cntl;
   logic        wr_dat;
   logic        tick;
   logic        fall_edge;
   logic [6:0]  crc_val;
   logic [31:0] rd_cntl;
   logic        unused_ok;

   assign busy      = (state_q == XFER);
   assign wr_cntl   = wstrb & sel_cntl & ~busy;
   assign wr_dat    = wstrb & sel_dat & ~busy;
   assign tick      = (divcnt_q == div_q);
   assign fall_edge = busy & tick & clk_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      divcnt_d = divcnt_q;
      bitcnt_d = bitcnt_q;
      clk_d    = clk_q;
      mosi_d   = mosi_q;
      csn_d    = csn_q;
      tx_d     = tx_q;
      rx_sh_d  = rx_sh_q;
      rx_d     = rx_q;
      case (state_q)
         IDLE: begin
            // cntl fields land first so a combined write starts with the new divider
            if (wr_cntl) begin
               csn_d = wdata[CSN_BIT];
               div_d = wdata[DIV_LSB +: 8];
            end
            if (wr_dat) begin
               tx_d     = wdata[7:0];
               mosi_d   = wdata[7];
               bitcnt_d = 3'd0;
               divcnt_d = 8'd0;
               clk_d    = 1'b0;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               divcnt_d = 8'd0;
               clk_d    = ~clk_q;
               if (!clk_q) begin
                  rx_sh_d = {rx_sh_q[6:0], MISO};
               end else if (bitcnt_q != 3'd7) begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  tx_d     = {tx_q[6:0], 1'b0};
                  mosi_d   = tx_q[6];
               end else begin
                  state_d = IDLE;
                  rx_d    = rx_sh_q;
               end
            end else begin
               divcnt_d = divcnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         div_q    <= INIT_DIV;
         divcnt_q <= 8'd0;
         bitcnt_q <= 3'd0;
         clk_q    <= 1'b0;
         mosi_q   <= 1'b1;
         csn_q    <= 1'b1;
         tx_q     <= 8'h00;
         rx_sh_q  <= 8'h00;
         rx_q     <= 8'hFF;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         divcnt_q <= divcnt_d;
         bitcnt_q <= bitcnt_d;
         clk_q    <= clk_d;
         mosi_q   <= mosi_d;
         csn_q    <= csn_d;
         tx_q     <= tx_d;
         rx_sh_q  <= rx_sh_d;
         rx_q     <= rx_d;
      end
   end

`ifdef SDCARD_SPI_CRC7_EN
   sd_crc7 u_crc7 (
      .clk   (clk),
      .rst_n (reset_n),
      .clr   (wr_cntl & wdata[CRC_CLR_BIT]),
      .en    (fall_edge),
      .din   (tx_q[7]),
      .crc   (crc_val)
   );
`else
   assign crc_val = 7'h00;
`endif

   always_comb begin
      rd_cntl                 = 32'h0;
      rd_cntl[BUSY_BIT]       = busy;
      rd_cntl[CSN_BIT]        = csn_q;
      rd_cntl[DIV_LSB +: 8]   = div_q;
      rd_cntl[CRC_LSB +: 7]   = crc_val;
      rdata = (sel_cntl ? rd_cntl : 32'h0) | (sel_dat ? {24'h0, rx_q} : 32'h0);
   end

   // Reads are combinational and need no strobe; upper write bits are reserved.
   assign unused_ok = &{1'b0, rstrb, fall_edge, wdata[31:16]};

   assign wbusy = busy;
   assign rbusy = busy & sel_dat;
   assign CLK   = clk_q;
   assign MOSI  = mosi_q;
   assign CS_N  = csn_q;

endmodule

// File: tb/tb_sdcard_spi_master.sv
// Directed bench for sdcard_spi_master: reset, transfer timing, loopback data, busy/stall, CRC7.
`timescale 1ns/1ps
module tb_sdcard_spi_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rstrb = 1'b0;
   logic        wstrb = 1'b0;
   logic        sel_cntl = 1'b0;
   logic        sel_dat = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        wbusy;
   logic        rbusy;
   logic        spi_clk;
   logic        mosi;
   logic        miso;
   logic        cs_n;
   logic        loop_en = 1'b0;

   int          n_chk = 0;
   int          n_bad = 0;
   int          rise_cnt = 0;
   logic [7:0]  mosi_bits = 8'h00;

   logic [7:0]  seq_cmd0 [5] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0]  seq_cmd8 [5] = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};

   assign miso = loop_en ? mosi : 1'b0;

   always #5 clk = ~clk;

   sdcard_spi_master dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rstrb    (rstrb),
      .wstrb    (wstrb),
      .sel_cntl (sel_cntl),
      .sel_dat  (sel_dat),
      .wdata    (wdata),
      .rdata    (rdata),
      .wbusy    (wbusy),
      .rbusy    (rbusy),
      .CLK      (spi_clk),
      .MOSI     (mosi),
      .MISO     (miso),
      .CS_N     (cs_n)
   );

   always @(posedge spi_clk) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[6:0], mosi};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic c, input logic d, input logic [31:0] v);
      @(negedge clk);
      sel_cntl = c;
      sel_dat  = d;
      wdata    = v;
      wstrb    = 1'b1;
      @(posedge clk);
      #1;
      wstrb    = 1'b0;
      sel_cntl = 1'b0;
      sel_dat  = 1'b0;
   endtask

   task automatic rd(input logic c, input logic d, output logic [31:0] v);
      @(negedge clk);
      sel_cntl = c;
      sel_dat  = d;
      rstrb    = 1'b1;
      #1 v = rdata;
      @(posedge clk);
      #1;
      rstrb    = 1'b0;
      sel_cntl = 1'b0;
      sel_dat  = 1'b0;
   endtask

   // Counts sampled busy cycles until IDLE; optionally raises a dat read at sample rd_at.
   task automatic wait_idle(input int rd_at, output int busy_cyc, output int rb_cyc);
      busy_cyc = 0;
      rb_cyc   = 0;
      while (wbusy && busy_cyc < 5000) begin
         if (busy_cyc == rd_at) begin
            sel_dat = 1'b1;
            rstrb   = 1'b1;
         end
         #1;
         if (rbusy) rb_cyc++;
         busy_cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic xfer(input logic [7:0] b, output int cyc);
      int rb;
      wr(1'b0, 1'b1, {24'h0, b});
      wait_idle(-1, cyc, rb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      int cyc;
      int rb;
      int r0;

      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;

      chk("rst_clk",   32'(spi_clk), 32'd0);
      chk("rst_mosi",  32'(mosi),    32'd1);
      chk("rst_csn",   32'(cs_n),    32'd1);
      chk("rst_wbusy", 32'(wbusy),   32'd0);
      chk("rst_rbusy", 32'(rbusy),   32'd0);
      rd(1'b0, 1'b0, v);
      chk("rd_nosel", v, 32'h0);
      rd(1'b1, 1'b0, v);
      chk("rst_cntl", v, 32'h0000_3F02);
      rd(1'b0, 1'b1, v);
      chk("rst_dat", v, 32'h0000_00FF);

      // div=0 loopback
      wr(1'b1, 1'b0, 32'h0);
      chk("csn_low", 32'(cs_n), 32'd0);
      loop_en = 1'b1;
      r0 = rise_cnt;
      xfer(8'hA5, cyc);
      chk("div0_cycles", 32'(cyc), 32'd16);
      chk("div0_rises", 32'(rise_cnt - r0), 32'd8);
      chk("div0_mosi", {24'h0, mosi_bits}, 32'h0000_00A5);
      rd(1'b0, 1'b1, v);
      chk("div0_dat", v, 32'h0000_00A5);
      rd(1'b1, 1'b0, v);
      chk("div0_cntl", v & 32'h0000_FFFF, 32'h0);

      // div=3, MISO low, dat read stalled mid-transfer
      loop_en = 1'b0;
      wr(1'b1, 1'b0, 32'h0000_0300);
      r0 = rise_cnt;
      wr(1'b0, 1'b1, 32'h0000_00FF);
      wait_idle(10, cyc, rb);
      chk("div3_cycles", 32'(cyc), 32'd64);
      chk("div3_rbusy_cyc", 32'(rb), 32'd54);
      chk("div3_rbusy_end", 32'(rbusy), 32'd0);
      chk("div3_dat", rdata, 32'h0);
      sel_dat = 1'b0;
      rstrb   = 1'b0;
      chk("div3_rises", 32'(rise_cnt - r0), 32'd8);
      chk("div3_mosi", {24'h0, mosi_bits}, 32'h0000_00FF);

      // div=255 upper bound
      loop_en = 1'b1;
      wr(1'b1, 1'b0, 32'h0000_FF00);
      xfer(8'hC3, cyc);
      chk("div255_cycles", 32'(cyc), 32'd4096);
      rd(1'b0, 1'b1, v);
      chk("div255_dat", v, 32'h0000_00C3);

      // cntl+dat in one write: new div=1 and CS_N=1 apply before the transfer
      wr(1'b1, 1'b1, 32'h0000_0183);
      chk("combo_csn", 32'(cs_n), 32'd1);
      wait_idle(-1, cyc, rb);
      chk("combo_cycles", 32'(cyc), 32'd32);
      rd(1'b0, 1'b1, v);
      chk("combo_dat", v, 32'h0000_0083);
      rd(1'b1, 1'b0, v);
      chk("combo_cntl", v & 32'h0000_FFFF, 32'h0000_0102);

      // writes while busy are dropped
      wr(1'b1, 1'b0, 32'h0000_0300);
      wr(1'b0, 1'b1, 32'h0000_003C);
      wr(1'b1, 1'b0, 32'h0000_0500);
      wr(1'b0, 1'b1, 32'h0000_0012);
      wait_idle(-1, cyc, rb);
      chk("busywr_cycles", 32'(cyc), 32'd62);
      rb = 0;
      for (int i = 0; i < 6; i++) begin
         if (wbusy) rb++;
         @(posedge clk);
         #1;
      end
      chk("busywr_noqueue", 32'(rb), 32'd0);
      rd(1'b1, 1'b0, v);
      chk("busywr_cntl", v & 32'h0000_FFFF, 32'h0000_0300);
      rd(1'b0, 1'b1, v);
      chk("busywr_dat", v, 32'h0000_003C);
      chk("busywr_mosi", {24'h0, mosi_bits}, 32'h0000_003C);

`ifdef SDCARD_SPI_CRC7_EN
      wr(1'b1, 1'b0, 32'h0001_0000);
      for (int i = 0; i < 5; i++) xfer(seq_cmd0[i], cyc);
      rd(1'b1, 1'b0, v);
      chk("crc_cmd0", (v >> 16) & 32'h7F, 32'h4A);
      wr(1'b1, 1'b0, 32'h0001_0000);
      for (int i = 0; i < 5; i++) xfer(seq_cmd8[i], cyc);
      rd(1'b1, 1'b0, v);
      chk("crc_cmd8", (v >> 16) & 32'h7F, 32'h43);
`else
      wr(1'b1, 1'b0, 32'h0001_0000);
      for (int i = 0; i < 5; i++) xfer(seq_cmd8[i], cyc);
      rd(1'b1, 1'b0, v);
      chk("nocrc_cntl", v, 32'h0);
      chk("nocrc_seq0", {24'h0, seq_cmd0[0]}, {24'h0, mosi_bits} ^ 32'h0000_00EA);
`endif

      // async reset in bit 4 of a div=7 transfer
      wr(1'b1, 1'b0, 32'h0000_0700);
      wr(1'b0, 1'b1, 32'h0000_0000);
      repeat (73) @(posedge clk);
      #1;
      chk("prerst_busy", 32'(wbusy),   32'd1);
      chk("prerst_clk",  32'(spi_clk), 32'd1);
      chk("prerst_mosi", 32'(mosi),    32'd0);
      chk("prerst_csn",  32'(cs_n),    32'd0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_csn",  32'(cs_n),    32'd1);
      chk("rst_mid_clk",  32'(spi_clk), 32'd0);
      chk("rst_mid_mosi", 32'(mosi),    32'd1);
      chk("rst_mid_busy", 32'(wbusy),   32'd0);
      @(negedge clk) reset_n = 1'b1;
      loop_en = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst_busy", 32'(wbusy), 32'd0);
      rd(1'b1, 1'b0, v);
      chk("postrst_cntl", v, 32'h0000_3F02);
      rd(1'b0, 1'b1, v);
      chk("postrst_dat", v, 32'h0000_00FF);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
